// File: rtl/down_timer_reload_if.sv
// Bus bundle for the down timer: control/load inputs from the master,
// count, borrow chain, terminal-count pulse and FSM state from the timer.
interface down_timer_reload_if #(
    parameter int WIDTH = 8
);
    logic               ld;
    logic               s_s;
    logic               mode;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH/4-1:0] br;
    logic               tc;
    logic               busy;
    logic [1:0]         state;   // debug view of the FSM: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE

    // Plain level interface, no handshake: the master drives ld/s_s/mode/d
    // and they are sampled on every rising clock edge; the timer's outputs
    // are valid every cycle (cnt/tc/busy/state registered, br combinational).
    modport master (output ld, s_s, mode, d, input cnt, br, tc, busy, state);
    modport slave  (input ld, s_s, mode, d, output cnt, br, tc, busy, state);
endinterface

// File: rtl/down_timer_reload.sv
// Programmable down-counter built from cascaded 4-bit slices chained by borrow,
// with a small FSM for one-shot or periodic (auto-reload) timing and a
// registered one-cycle terminal-count pulse.
module down_timer_reload #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                clr_n,
    down_timer_reload_if.slave bus
);
    localparam int NS = WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_dec, rld_q;
    logic             tc_q;
    logic             run_ok, dec_en, term;
    logic [NS-1:0]    slice_en, br;

    // Decrement enable and terminal event; ld always wins over counting.
    always_comb begin
        run_ok = (state_q == RUN) || (state_q == PAUSE) ||
                 ((state_q == IDLE) && (cnt_q != '0));
        dec_en = bus.s_s && !bus.ld && run_ok;
        term   = dec_en && (cnt_q == WIDTH'(1));
    end

    // Nibble slices: each decrements when the slice below borrows;
    // a slice at zero passes the borrow up and wraps to F.
    for (genvar i = 0; i < NS; i++) begin : g_slice
        if (i == 0) begin : g_first
            assign slice_en[i] = dec_en;
        end else begin : g_next
            assign slice_en[i] = br[i-1];
        end
        assign br[i]            = slice_en[i] && (cnt_q[4*i +: 4] == 4'd0);
        assign cnt_dec[4*i +: 4] = slice_en[i] ? (cnt_q[4*i +: 4] - 4'd1)
                                               : cnt_q[4*i +: 4];
    end

    // Next count and next state; the terminal event overrides the slice
    // result so the count never wraps below zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.ld) begin
            state_d = IDLE;
            cnt_d   = bus.d;
        end else begin
            if (term) begin
                cnt_d = bus.mode ? rld_q : '0;
            end else if (dec_en) begin
                cnt_d = cnt_dec;
            end
            case (state_q)
                IDLE:    if (dec_en) state_d = RUN;
                RUN:     if (!bus.s_s) state_d = PAUSE;
                PAUSE:   if (bus.s_s) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
            if (term && !bus.mode) begin
                state_d = DONE;
            end
        end
    end

    // State, count, reload value and terminal-count pulse registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= term;
            if (bus.ld) begin
                rld_q <= bus.d;
            end
        end
    end

    assign bus.cnt   = cnt_q;
    assign bus.br    = br;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
    assign bus.state = state_q;
endmodule

// File: tb/tb_down_timer_reload.sv
// Bench for down_timer_reload: directed per-cycle vectors with hand-computed
// expected responses for an 8-bit and a 12-bit build.
module tb_down_timer_reload;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic clr_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    down_timer_reload_if #(.WIDTH(8))  if8 ();
    down_timer_reload_if #(.WIDTH(12)) if12 ();

    down_timer_reload #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (if8.slave)
    );

    down_timer_reload #(.WIDTH(12)) u_dut12 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (if12.slave)
    );

    // ---------------- scoreboard state ----------------
    // packed expectation: {state, br, busy, tc, cnt}
    logic [13:0] exp8_q[$];
    logic [18:0] exp12_q[$];
    int checks   = 0;
    int failures = 0;
    int idx8     = 0;
    int idx12    = 0;

    // ---------------- driver tasks ----------------
    task automatic step8(input logic ld, input logic s_s, input logic mode,
                         input logic [7:0] d, input logic [7:0] e_cnt,
                         input logic e_tc, input logic e_busy,
                         input logic [1:0] e_st, input logic [1:0] e_br);
        @(negedge clk);
        if8.ld   = ld;
        if8.s_s  = s_s;
        if8.mode = mode;
        if8.d    = d;
        exp8_q.push_back({e_st, e_br, e_busy, e_tc, e_cnt});
    endtask

    task automatic step12(input logic ld, input logic s_s, input logic mode,
                          input logic [11:0] d, input logic [11:0] e_cnt,
                          input logic e_tc, input logic e_busy,
                          input logic [1:0] e_st, input logic [2:0] e_br);
        @(negedge clk);
        if12.ld   = ld;
        if12.s_s  = s_s;
        if12.mode = mode;
        if12.d    = d;
        exp12_q.push_back({e_st, e_br, e_busy, e_tc, e_cnt});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp8_q.size() > 0 || exp12_q.size() > 0) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp8_q.size() > 0 || exp12_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending8=%0d pending12=%0d exp=0",
                     exp8_q.size(), exp12_q.size());
        end
    endtask

    // ---------------- monitors ----------------
    // Outputs are presented every cycle; sample 1 time unit after the edge.
    always @(posedge clk) begin
        logic [13:0] e8, g8;
        #1;
        if (exp8_q.size() > 0) begin
            e8 = exp8_q.pop_front();
            g8 = {if8.state, if8.br, if8.busy, if8.tc, if8.cnt};
            checks++;
            if (g8 !== e8) begin
                failures++;
                $display("FAIL w8_step%0d got st=%0d br=%b busy=%b tc=%b cnt=%h exp st=%0d br=%b busy=%b tc=%b cnt=%h",
                         idx8, g8[13:12], g8[11:10], g8[9], g8[8], g8[7:0],
                         e8[13:12], e8[11:10], e8[9], e8[8], e8[7:0]);
            end
            idx8++;
        end
    end

    always @(posedge clk) begin
        logic [18:0] e12, g12;
        #1;
        if (exp12_q.size() > 0) begin
            e12 = exp12_q.pop_front();
            g12 = {if12.state, if12.br, if12.busy, if12.tc, if12.cnt};
            checks++;
            if (g12 !== e12) begin
                failures++;
                $display("FAIL w12_step%0d got st=%0d br=%b busy=%b tc=%b cnt=%h exp st=%0d br=%b busy=%b tc=%b cnt=%h",
                         idx12, g12[18:17], g12[16:14], g12[13], g12[12], g12[11:0],
                         e12[18:17], e12[16:14], e12[13], e12[12], e12[11:0]);
            end
            idx12++;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        clr_n = 1'b0;
        if8.ld = 1'b0;  if8.s_s = 1'b0;  if8.mode = 1'b0;  if8.d = '0;
        if12.ld = 1'b0; if12.s_s = 1'b0; if12.mode = 1'b0; if12.d = '0;
        repeat (2) @(negedge clk);
        chk("reset_hold8", {18'd0, if8.state, if8.br, if8.busy, if8.tc, if8.cnt}, 32'd0);
        clr_n = 1'b1;

        // one-shot from 3
        //    ld s_s mode d      cnt    tc busy state     br
        step8(1, 0, 0, 8'h03, 8'h03, 0, 0, ST_IDLE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h02, 0, 1, ST_RUN,   2'b00);
        step8(0, 1, 0, 8'h00, 8'h01, 0, 1, ST_RUN,   2'b00);
        step8(0, 1, 0, 8'h00, 8'h00, 1, 0, ST_DONE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h00, 0, 0, ST_DONE,  2'b00);

        // borrow across the nibble boundary
        step8(1, 0, 0, 8'h11, 8'h11, 0, 0, ST_IDLE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h10, 0, 1, ST_RUN,   2'b01);
        step8(0, 1, 0, 8'h00, 8'h0F, 0, 1, ST_RUN,   2'b00);
        step8(0, 1, 0, 8'h00, 8'h0E, 0, 1, ST_RUN,   2'b00);

        // pause at 3, resume, then abort with a load
        step8(1, 0, 0, 8'h05, 8'h05, 0, 0, ST_IDLE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h04, 0, 1, ST_RUN,   2'b00);
        step8(0, 1, 0, 8'h00, 8'h03, 0, 1, ST_RUN,   2'b00);
        step8(0, 0, 0, 8'h00, 8'h03, 0, 1, ST_PAUSE, 2'b00);
        step8(0, 0, 0, 8'h00, 8'h03, 0, 1, ST_PAUSE, 2'b00);
        step8(0, 0, 0, 8'h00, 8'h03, 0, 1, ST_PAUSE, 2'b00);
        step8(0, 1, 0, 8'h00, 8'h02, 0, 1, ST_RUN,   2'b00);
        step8(1, 1, 0, 8'h20, 8'h20, 0, 0, ST_IDLE,  2'b00);
        step8(0, 0, 0, 8'h00, 8'h20, 0, 0, ST_IDLE,  2'b00);

        // periodic with reload 4: twelve enabled cycles, three tc pulses
        step8(1, 0, 1, 8'h04, 8'h04, 0, 0, ST_IDLE,  2'b00);
        for (int p = 0; p < 3; p++) begin
            step8(0, 1, 1, 8'h00, 8'h03, 0, 1, ST_RUN, 2'b00);
            step8(0, 1, 1, 8'h00, 8'h02, 0, 1, ST_RUN, 2'b00);
            step8(0, 1, 1, 8'h00, 8'h01, 0, 1, ST_RUN, 2'b00);
            step8(0, 1, 1, 8'h00, 8'h04, 1, 1, ST_RUN, 2'b00);
        end

        // periodic with reload 1: tc every enabled cycle; then one-shot ends it
        step8(1, 0, 1, 8'h01, 8'h01, 0, 0, ST_IDLE,  2'b00);
        step8(0, 1, 1, 8'h00, 8'h01, 1, 1, ST_RUN,   2'b00);
        step8(0, 1, 1, 8'h00, 8'h01, 1, 1, ST_RUN,   2'b00);
        step8(0, 1, 1, 8'h00, 8'h01, 1, 1, ST_RUN,   2'b00);
        step8(0, 1, 0, 8'h00, 8'h00, 1, 0, ST_DONE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h00, 0, 0, ST_DONE,  2'b00);

        // zero start never leaves IDLE
        step8(1, 1, 0, 8'h00, 8'h00, 0, 0, ST_IDLE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h00, 0, 0, ST_IDLE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h00, 0, 0, ST_IDLE,  2'b00);

        // get into RUN at 0x37, then reset asynchronously between edges
        step8(1, 0, 0, 8'h38, 8'h38, 0, 0, ST_IDLE,  2'b00);
        step8(0, 1, 0, 8'h00, 8'h37, 0, 1, ST_RUN,   2'b00);
        drain();
        #1;
        clr_n = 1'b0;
        #1;
        chk("async_reset8", {18'd0, if8.state, if8.br, if8.busy, if8.tc, if8.cnt}, 32'd0);
        @(negedge clk);
        if8.s_s = 1'b0;
        clr_n = 1'b1;

        // 12-bit build: borrow ripples through two zero slices
        //     ld s_s mode d        cnt      tc busy state     br
        step12(1, 0, 0, 12'h101, 12'h101, 0, 0, ST_IDLE,  3'b000);
        step12(0, 1, 0, 12'h000, 12'h100, 0, 1, ST_RUN,   3'b011);
        step12(0, 1, 0, 12'h000, 12'h0FF, 0, 1, ST_RUN,   3'b000);
        step12(0, 1, 0, 12'h000, 12'h0FE, 0, 1, ST_RUN,   3'b000);
        step12(0, 0, 0, 12'h000, 12'h0FE, 0, 1, ST_PAUSE, 3'b000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
